s_mem_verify_fsm: RTL
=====================

Name: s_mem_verify_fsm

Overview:
- Read-side companion to the S-memory initialiser in the RC4 decoder datapath.
- Sweeps all 256 words of the 8-bit x 256 S RAM through the RAM's read port and checks the returned data.
- Identity mode confirms the initial fill S[i]==i. Permutation mode confirms the contents after key scheduling are a valid permutation of 0..255.
- Drives the same RAM address/rden/wren interface as the initialiser; the top level muxes the two onto the RAM.

Parameters:
- READ_LATENCY, 1, RAM clocks from address presented to q valid (legal values 1 or 2).
- CHECK_MODE, 0, 0 = identity check (q must equal address); 1 = permutation check (every value 0..255 seen exactly once).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a sweep; sampled only in IDLE
- q  in  8  RAM read data
- address  out  8  RAM address
- rden  out  1  RAM read enable
- wren  out  1  RAM write enable; constant 0
- busy  out  1  high from the edge after start is accepted until DONE
- done  out  1  level; high in DONE until the next start is accepted
- pass  out  1  valid while done=1; high iff err_count==0
- err_count  out  9  number of failing words, 0..256

Behaviour:
- Reset (async, active-low): state=IDLE; address=0, rden=0, wren=0, busy=0, done=0, pass=0, err_count=0; valid pipe and seen bitmap cleared.
- Reset asserted mid-sweep aborts the sweep immediately with the same values; no partial result is kept.
- IDLE -> READ when start=1 (edge 0): address=0, rden=1, busy=1, done=0, pass=0, err_count=0, bitmap cleared.
- READ:
  - address increments by 1 per clock through 255; rden stays 1.
  - On the edge where address==255, go to DRAIN and set rden=0.
  - Address never wraps within a sweep.
- DRAIN: hold for READ_LATENCY clocks so the last word's q returns, then go to DONE.
- DONE: busy=0, done=1, pass=(err_count==0). DONE -> READ on start=1, re-initialising exactly as from IDLE.
- start is ignored while busy=1.
- Read pipeline:
  - A (READ_LATENCY+1)-deep shift register carries a valid bit plus the issued address.
  - A word is compared when its tag reaches the end of the pipe; q is sampled on that edge.
  - done rises on edge 257+READ_LATENCY counted from edge 0.
- Identity mode: error when q != tagged address.
- Permutation mode:
  - 256-bit seen bitmap; error when seen[q] is already 1, then seen[q] is set.
  - Duplicates equal missing values, so one count per duplicate is sufficient.
- err_count increments by 1 per error and cannot exceed 256 (9 bits); no saturation logic is needed.
- wren is never asserted, so the block is a read-only master.

Optional Feature:
- Macro: S_MEM_VERIFY_CAPTURE_EN.
- When defined, adds outputs first_err_addr[7:0] and first_err_data[7:0] plus a first_err_valid flag.
  - They latch the tagged address and q of the first failing word in a sweep.
  - They clear on start acceptance and on reset.
- When not defined, these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package s_mem_pkg holds:
  - S_DEPTH=256 and S_AW=8;
  - the state enum typedef {IDLE, READ, DRAIN, DONE};
  - the check-mode constants CHK_IDENTITY=0 and CHK_PERMUTE=1.
- One natural sub-module: s_mem_read_pipe, the parameterised valid/address tag delay line (depth READ_LATENCY+1).
- The comparator and the bitmap stay in the top module.

Test Plan:
- RAM model preloaded with S[i]=i, CHECK_MODE=0, READ_LATENCY=1, start pulse -> address 0..255 with rden high 256 cycles; done rises at edge 258; pass=1, err_count=0.
- Same preload but S[17]=0x44 and S[200]=0x00 -> err_count=2, pass=0. With S_MEM_VERIFY_CAPTURE_EN: first_err_addr=17, first_err_data=0x44.
- CHECK_MODE=1, RAM holds a valid permutation S[i]=255-i, READ_LATENCY=2 -> pass=1, err_count=0, done at edge 259.
- CHECK_MODE=1, permutation with S[5] overwritten to equal S[9] -> err_count=1, pass=0.
- Reset driven low at address 120 mid-sweep -> outputs return to reset values at once; a new start yields a full 256-read sweep and a correct result.
- start held high through the sweep and into DONE -> no restart while busy; a new sweep begins the cycle after DONE is reached with start=1, and done drops.

Source files
------------

// File: rtl/s_mem_pkg.sv
// Shared types and constants for the RC4 S-memory init/verify blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package s_mem_pkg;

  localparam int S_DEPTH = 256;
  localparam int S_AW    = 8;

  localparam int CHK_IDENTITY = 0;
  localparam int CHK_PERMUTE  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/s_mem_read_pipe.sv
// Valid/address tag delay line that pairs each issued read with its returning RAM data.
// Latency: DEPTH clocks from in_vld/in_addr to out_vld/out_addr.
// Backpressure: none; shifts every clock.
module s_mem_read_pipe
  import s_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_vld,
  input  logic [S_AW-1:0] in_addr,
  output logic            out_vld,
  output logic [S_AW-1:0] out_addr
);

  logic [DEPTH-1:0] vld_q;
  logic [S_AW-1:0]  addr_q [DEPTH];

  // Shift the tag one stage per clock; reset drops any in-flight reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
    end else begin
      vld_q[0]  <= in_vld;
      addr_q[0] <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_addr = addr_q[DEPTH-1];

endmodule

// File: rtl/s_mem_verify_fsm.sv
// Sweeps the 256-word S RAM and checks identity fill or permutation; optional first-error
// capture under S_MEM_VERIFY_CAPTURE_EN. Latency: done rises 257+READ_LATENCY clocks after start.
// Backpressure: none; start is ignored while busy, read port is driven every clock of the sweep.
module s_mem_verify_fsm
  import s_mem_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int CHECK_MODE   = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [7:0]      q,
  output logic [7:0]      address,
  output logic            rden,
  output logic            wren,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [8:0]      err_count
`ifdef S_MEM_VERIFY_CAPTURE_EN
  ,
  output logic            first_err_valid,
  output logic [7:0]      first_err_addr,
  output logic [7:0]      first_err_data
`endif
);

  localparam bit         PERMUTE    = (CHECK_MODE == CHK_PERMUTE);
  localparam logic [1:0] DRAIN_LAST = 2'(READ_LATENCY);

  state_t             state_q, state_d;
  logic [S_AW-1:0]    address_d;
  logic               rden_d, busy_d, done_d, pass_d;
  logic [1:0]         drain_cnt, drain_cnt_d;
  logic               start_acc;

  logic               chk_vld;
  logic [S_AW-1:0]    chk_addr;
  logic               word_err;
  logic [S_DEPTH-1:0] seen;

  // The RAM is never written by this block.
  assign wren = 1'b0;

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      address   <= '0;
      rden      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      drain_cnt <= '0;
    end else begin
      state_q   <= state_d;
      address   <= address_d;
      rden      <= rden_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      drain_cnt <= drain_cnt_d;
    end
  end

  // Next-state and next-output decode; the last address is issued once, then we drain.
  always_comb begin
    state_d     = state_q;
    address_d   = address;
    rden_d      = rden;
    busy_d      = busy;
    done_d      = done;
    pass_d      = pass;
    drain_cnt_d = drain_cnt;
    start_acc   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = READ;
          address_d = '0;
          rden_d    = 1'b1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
        end
      end
      READ: begin
        if (address == 8'd255) begin
          state_d     = DRAIN;
          rden_d      = 1'b0;
          drain_cnt_d = '0;
        end else begin
          address_d = address + 8'd1;
        end
      end
      DRAIN: begin
        // The final tag leaves the pipe one edge before this count expires.
        if (drain_cnt == DRAIN_LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_count == 9'd0);
        end else begin
          drain_cnt_d = drain_cnt + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tags are launched with the address as it is registered, so they align with q.
  s_mem_read_pipe #(
    .DEPTH (READ_LATENCY + 1)
  ) u_read_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_vld   (rden_d),
    .in_addr  (address_d),
    .out_vld  (chk_vld),
    .out_addr (chk_addr)
  );

  // Per-word comparison against the tagged address or the seen bitmap.
  always_comb begin
    word_err = 1'b0;
    if (chk_vld) begin
      if (PERMUTE) word_err = seen[q];
      else         word_err = (q != chk_addr);
    end
  end

  // Error counter and seen bitmap; both restart on each accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
      seen      <= '0;
    end else if (start_acc) begin
      err_count <= '0;
      seen      <= '0;
    end else if (chk_vld) begin
      if (PERMUTE) seen[q] <= 1'b1;
      if (word_err) err_count <= err_count + 9'd1;
    end
  end

`ifdef S_MEM_VERIFY_CAPTURE_EN
  // Latch the first failing word of the sweep.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
      first_err_data  <= '0;
    end else if (start_acc) begin
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
      first_err_data  <= '0;
    end else if (word_err && !first_err_valid) begin
      first_err_valid <= 1'b1;
      first_err_addr  <= chk_addr;
      first_err_data  <= q;
    end
  end
`endif

endmodule
